// File: rtl/control_filtro.sv
// -----------------------------------------------------------------------------
// control_filtro
// Sequencer for a 3-tap FIR filter, y[n] = coef0*x[n] + coef1*x[n-1] +
// coef2*x[n-2]. The block does no arithmetic of its own. It drives operands
// and an operation code to an external arithmetic unit, one operation per
// cycle, and registers the results that come back.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   inicio              start request, accepted only in IDLE
//   x_in                new sample x[n], captured when inicio is accepted
//   coef0..coef2        coefficients, held stable by the user while ocupado=1
//   limpiar             clears the sample history, effective only in IDLE
//   ua_a, ua_b, ua_func operands and operation to the arithmetic unit
//                       (0 NOP, 1 add, 2 subtract, 3 multiply)
//   ua_y, ua_overflow   combinational result and overflow from the unit
//   ocupado             high in every state except IDLE
//   listo               one-cycle pulse; y_out/desborde valid while high
//   y_out, desborde     registered result and overflow summary, held
//   estado              current FSM state, for observation
//
// Handshake: a request is taken on a rising edge where inicio=1 and
// ocupado=0. There is no queueing, so inicio while busy is dropped.
// listo rises in the 6th cycle after the accepting edge. The next request
// can be accepted 7 cycles after the previous one.
// -----------------------------------------------------------------------------
module control_filtro #(
  parameter int ANCHO = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inicio,
  input  logic [ANCHO-1:0] x_in,
  input  logic [ANCHO-1:0] coef0,
  input  logic [ANCHO-1:0] coef1,
  input  logic [ANCHO-1:0] coef2,
  input  logic             limpiar,
  output logic [ANCHO-1:0] ua_a,
  output logic [ANCHO-1:0] ua_b,
  output logic [2:0]       ua_func,
  input  logic [ANCHO-1:0] ua_y,
  input  logic             ua_overflow,
  output logic             ocupado,
  output logic             listo,
  output logic [ANCHO-1:0] y_out,
  output logic             desborde,
  output logic [2:0]       estado
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL0 = 3'd1,
    MUL1 = 3'd2,
    SUM1 = 3'd3,
    MUL2 = 3'd4,
    SUM2 = 3'd5,
    FIN  = 3'd6
  } state_t;

  localparam logic [2:0] OP_NOP = 3'h0;
  localparam logic [2:0] OP_ADD = 3'h1;
  localparam logic [2:0] OP_MUL = 3'h3;

  state_t           state, state_next;
  logic [ANCHO-1:0] xn, x1, x2;
  logic [ANCHO-1:0] acc, prod;
  logic             ovf_acc;

  // Next state and arithmetic-unit drive
  always_comb begin
    state_next = state;
    ua_a       = '0;
    ua_b       = '0;
    ua_func    = OP_NOP;
    case (state)
      IDLE: if (inicio) state_next = MUL0;
      MUL0: begin
        ua_a = xn;  ua_b = coef0; ua_func = OP_MUL; state_next = MUL1;
      end
      MUL1: begin
        ua_a = x1;  ua_b = coef1; ua_func = OP_MUL; state_next = SUM1;
      end
      SUM1: begin
        ua_a = acc; ua_b = prod;  ua_func = OP_ADD; state_next = MUL2;
      end
      MUL2: begin
        ua_a = x2;  ua_b = coef2; ua_func = OP_MUL; state_next = SUM2;
      end
      SUM2: begin
        ua_a = acc; ua_b = prod;  ua_func = OP_ADD; state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xn       <= '0;
      x1       <= '0;
      x2       <= '0;
      acc      <= '0;
      prod     <= '0;
      ovf_acc  <= 1'b0;
      y_out    <= '0;
      desborde <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A clear together with a start empties the history before the
          // new sample is computed. x1/x2 are first read in MUL1, so the
          // clear has already landed by then.
          if (limpiar) begin
            x1 <= '0;
            x2 <= '0;
          end
          if (inicio) begin
            xn      <= x_in;
            ovf_acc <= 1'b0;
          end
        end
        MUL0: begin
          acc     <= ua_y;
          ovf_acc <= ovf_acc | ua_overflow;
        end
        MUL1, MUL2: begin
          prod    <= ua_y;
          ovf_acc <= ovf_acc | ua_overflow;
        end
        SUM1: begin
          acc     <= ua_y;
          ovf_acc <= ovf_acc | ua_overflow;
        end
        SUM2: begin
          // The final sum is being formed this cycle. Publish it, and its
          // overflow, directly instead of waiting one more cycle for acc.
          acc      <= ua_y;
          ovf_acc  <= ovf_acc | ua_overflow;
          y_out    <= ua_y;
          desborde <= ovf_acc | ua_overflow;
          x2       <= x1;
          x1       <= xn;
        end
        default: ;
      endcase
    end
  end

  assign ocupado = (state != IDLE);
  assign listo   = (state == FIN);
  assign estado  = state;

endmodule

// File: tb/tb_control_filtro.sv
module tb_control_filtro;
  localparam int W = 25;

  logic         clk = 1'b0;
  logic         reset, inicio, limpiar;
  logic [W-1:0] x_in, coef0, coef1, coef2;
  logic [W-1:0] ua_a, ua_b, ua_y, y_out;
  logic [2:0]   ua_func, estado;
  logic         ua_overflow, ocupado, listo, desborde;

  int errors = 0;
  int checks = 0;

  // Reference history, kept as plain integers
  longint m_x1, m_x2;
  logic [W-1:0] exp_q[$];

  // Clock and reset
  always #5 clk = ~clk;

  control_filtro #(.ANCHO(W)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .x_in(x_in),
    .coef0(coef0), .coef1(coef1), .coef2(coef2), .limpiar(limpiar),
    .ua_a(ua_a), .ua_b(ua_b), .ua_func(ua_func), .ua_y(ua_y),
    .ua_overflow(ua_overflow), .ocupado(ocupado), .listo(listo),
    .y_out(y_out), .desborde(desborde), .estado(estado)
  );

  // Behavioural arithmetic unit: result is the low W bits, and overflow is
  // raised when the exact result does not fit in W signed bits.
  logic [2*W-1:0] full;
  always_comb begin
    full        = '0;
    ua_y        = '0;
    ua_overflow = 1'b0;
    case (ua_func)
      3'h1: full = {{W{ua_a[W-1]}}, ua_a} + {{W{ua_b[W-1]}}, ua_b};
      3'h2: full = {{W{ua_a[W-1]}}, ua_a} - {{W{ua_b[W-1]}}, ua_b};
      3'h3: full = {{W{ua_a[W-1]}}, ua_a} * {{W{ua_b[W-1]}}, ua_b};
      default: full = '0;
    endcase
    ua_y        = full[W-1:0];
    ua_overflow = (full != {{W{full[W-1]}}, full[W-1:0]});
  end

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint wrap(input longint v);
    logic [W-1:0] t;
    t = v[W-1:0];
    return longint'($signed(t));
  endfunction

  // Reference model: FIR over integers, wrapping each step to W bits.
  // Advances the history.
  task automatic model(input logic [W-1:0] x0, output logic [W-1:0] y,
                       output logic ov);
    longint e0, e1, e2, p0, p1, p2, s1, s2;
    e0 = sx(coef0) * sx(x0);  p0 = wrap(e0);
    e1 = sx(coef1) * m_x1;    p1 = wrap(e1);
    s1 = wrap(p0 + p1);
    e2 = sx(coef2) * m_x2;    p2 = wrap(e2);
    s2 = wrap(s1 + p2);
    ov = (p0 != e0) || (p1 != e1) || (s1 != p0 + p1) ||
         (p2 != e2) || (s2 != s1 + p2);
    y  = s2[W-1:0];
    m_x2 = m_x1;
    m_x1 = sx(x0);
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_small();
    int v;
    v = int'($urandom_range(0, 2000)) - 1000;
    return W'(v);
  endfunction

  // Driver: one sample, starting and ending at a falling edge with the DUT
  // idle. With noise set, inicio/limpiar are toggled while busy; the DUT
  // must ignore them.
  task automatic do_sample(input string tag, input logic [W-1:0] x,
                           input logic lim, input logic noise);
    logic [W-1:0] ey;
    logic         eo;
    int           k;
    if (lim) begin m_x1 = 0; m_x2 = 0; end
    model(x, ey, eo);
    inicio = 1'b1; limpiar = lim; x_in = x;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0; limpiar = 1'b0;
    k = 1;
    check({tag, "_busy"}, W'(ocupado), W'(1));
    while (!listo && k < 20) begin
      if (noise) begin
        inicio  = 1'($urandom_range(0, 1));
        limpiar = 1'($urandom_range(0, 1));
        x_in    = W'($urandom);
      end
      @(negedge clk);
      k++;
    end
    inicio = 1'b0; limpiar = 1'b0;
    check({tag, "_latency"}, W'(k), W'(6));
    check({tag, "_y"}, y_out, ey);
    check({tag, "_ovf"}, W'(desborde), W'(eo));
    @(negedge clk);
    check({tag, "_pulse"}, W'(listo), W'(0));
    check({tag, "_idle"}, W'(ocupado), W'(0));
    check({tag, "_hold"}, y_out, ey);
  endtask

  task automatic set_coefs(input logic [W-1:0] c0, c1, c2);
    coef0 = c0; coef1 = c1; coef2 = c2;
  endtask

  initial begin
    int next_free, last_acc, nlisto;
    logic [W-1:0] ey;
    logic         eo;

    reset = 1'b1; inicio = 1'b0; limpiar = 1'b0; x_in = '0;
    set_coefs(W'(1), W'(2), W'(3));
    m_x1 = 0; m_x2 = 0;
    #1;
    check("rst_ocupado", W'(ocupado), W'(0));
    check("rst_listo", W'(listo), W'(0));
    check("rst_y", y_out, W'(0));
    check("rst_ovf", W'(desborde), W'(0));
    check("rst_func", W'(ua_func), W'(0));
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // A/B: 5, 7, 1 with coefficients (1,2,3)
    do_sample("a_x5", W'(5), 1'b0, 1'b0);
    check("a_const", y_out, W'(5));
    do_sample("b_x7", W'(7), 1'b0, 1'b0);
    check("b_const7", y_out, W'(17));
    do_sample("b_x1", W'(1), 1'b0, 1'b1);
    check("b_const1", y_out, W'(30));

    // E: reset during SUM1 aborts the computation and clears the history
    inicio = 1'b1; x_in = W'(9);
    @(posedge clk);
    @(negedge clk); inicio = 1'b0;   // MUL0
    @(negedge clk);                  // MUL1
    @(negedge clk);                  // SUM1
    check("e_func_sum1", W'(ua_func), W'(1));
    reset = 1'b1;
    #1;
    check("e_rst_listo", W'(listo), W'(0));
    check("e_rst_ocupado", W'(ocupado), W'(0));
    check("e_rst_y", y_out, W'(0));
    check("e_rst_ovf", W'(desborde), W'(0));
    check("e_rst_func", W'(ua_func), W'(0));
    m_x1 = 0; m_x2 = 0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    nlisto = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (listo) nlisto++;
    end
    check("e_no_listo", W'(nlisto), W'(0));
    do_sample("e_x5", W'(5), 1'b0, 1'b0);
    check("e_const", y_out, W'(5));

    // F: history 5,7 then clear+start with x=4
    do_sample("f_x7", W'(7), 1'b0, 1'b0);
    do_sample("f_clr4", W'(4), 1'b1, 1'b0);
    check("f_const", y_out, W'(4));

    // Clear on its own, then a sample
    limpiar = 1'b1;
    @(posedge clk);
    @(negedge clk);
    limpiar = 1'b0; m_x1 = 0; m_x2 = 0;
    do_sample("clr_x6", W'(6), 1'b0, 1'b0);

    // C: inicio held for 20 cycles; accepts at 7-cycle spacing only
    next_free = 0; last_acc = -100; nlisto = 0;
    for (int j = 0; j < 27; j++) begin
      inicio = (j < 20);
      x_in   = W'($urandom_range(0, 100));
      if (j < 20 && j >= next_free) begin
        next_free = j + 7;
        last_acc  = j;
        model(x_in, ey, eo);
        exp_q.push_back(ey);
      end
      @(posedge clk);
      @(negedge clk);
      check("c_ocupado", W'(ocupado), W'(j >= last_acc && j <= last_acc + 5));
      check("c_listo", W'(listo), W'(j == last_acc + 5));
      if (listo) begin
        nlisto++;
        if (exp_q.size() > 0) check("c_y", y_out, exp_q.pop_front());
      end
    end
    inicio = 1'b0;
    check("c_count", W'(nlisto), W'(3));
    check("c_drain", W'(exp_q.size()), W'(0));

    // D: overflowing multiply, then a clean sample
    set_coefs(W'(25'h0FFFFFF), W'(2), W'(3));
    do_sample("d_ovf", W'(2), 1'b0, 1'b0);
    check("d_ovf_const", W'(desborde), W'(1));
    set_coefs(W'(1), W'(2), W'(3));
    do_sample("d_clean", W'(3), 1'b0, 1'b0);
    check("d_clean_const", W'(desborde), W'(0));

    // Random samples and coefficients, small and full range
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0)
        set_coefs(W'($urandom), W'($urandom), W'($urandom));
      else
        set_coefs(rnd_small(), rnd_small(), rnd_small());
      do_sample("rnd",
                ($urandom_range(0, 3) == 0) ? W'($urandom) : rnd_small(),
                ($urandom_range(0, 7) == 0), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
